// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared CPU definitions: AXI encodings and the uncached fetch
//               state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

  // AXI encodings used by the fetch path
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Uncached fetch state machine
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_AR   = 2'd1,
    FS_R    = 2'd2,
    FS_DONE = 2'd3
  } fetch_state_e;

endpackage : cpu_defs

`default_nettype wire

// File: rtl/inst_uc_fetch.sv
// ============================================================================
// Module      : inst_uc_fetch
// Description : Uncached instruction fetch engine. Converts one fetch request
//               into a single-beat AXI4 read and returns the 32-bit word.
//               A flush during the bus transaction lets the transaction finish
//               but discards the returned data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_uc_fetch
  import cpu_defs::*;
#(
  parameter int              ID_W  = 4,
  parameter logic [ID_W-1:0] AR_ID = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  // PC / IF stage side
  input  logic            req_i,
  input  logic [31:0]     addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [31:0]     inst_o,
  output logic            valid_o,
  output logic            bus_err_o,
  // AXI read address channel
  output logic [ID_W-1:0] arid_o,
  output logic [31:0]     araddr_o,
  output logic [7:0]      arlen_o,
  output logic [2:0]      arsize_o,
  output logic [1:0]      arburst_o,
  output logic [1:0]      arlock_o,
  output logic [3:0]      arcache_o,
  output logic [2:0]      arprot_o,
  output logic            arvalid_o,
  input  logic            arready_i,
  // AXI read data channel
  input  logic [ID_W-1:0] rid_i,
  input  logic [31:0]     rdata_i,
  input  logic [1:0]      rresp_i,
  input  logic            rlast_i,
  input  logic            rvalid_i,
  output logic            rready_o
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [31:0]  inst_q, inst_d;
  logic         valid_q, valid_d;
  logic         bus_err_q, bus_err_d;
  logic         arvalid_q, arvalid_d;
  logic         rready_q, rready_d;
  logic         w_accept;

  // Only one transaction is ever outstanding, so the returned ID carries no
  // information.
  logic unused_rid;
  assign unused_rid = ^rid_i;

  assign w_accept = req_i & ~flush_i;

  // Next-state logic for the fetch FSM and its datapath registers
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    araddr_d  = araddr_q;
    inst_d    = inst_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    valid_d   = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (w_accept) begin
          araddr_d  = addr_i;
          kill_d    = 1'b0;
          arvalid_d = 1'b1;
          state_d   = FS_AR;
        end
      end
      FS_AR: begin
        if (flush_i) kill_d = 1'b1;
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = FS_R;
        end
      end
      FS_R: begin
        if (flush_i) kill_d = 1'b1;
        // A beat without rlast is a protocol violation and is dropped.
        if (rvalid_i && rlast_i) begin
          rready_d = 1'b0;
          // A flush in the very cycle of the beat also kills the fetch.
          if (kill_q || flush_i) begin
            state_d = FS_IDLE;
          end else begin
            inst_d    = rdata_i;
            valid_d   = 1'b1;
            bus_err_d = (rresp_i != AXI_RESP_OKAY);
            state_d   = FS_DONE;
          end
        end
      end
      FS_DONE: begin
        state_d = FS_IDLE;
      end
      default: begin
        state_d   = FS_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FS_IDLE;
      kill_q    <= 1'b0;
      araddr_q  <= 32'h0;
      inst_q    <= 32'h0;
      valid_q   <= 1'b0;
      bus_err_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      araddr_q  <= araddr_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
      bus_err_q <= bus_err_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  // Combinational so the PC holds in the same cycle the request is seen.
  assign stall_o = ((state_q == FS_IDLE) & w_accept) |
                   (state_q == FS_AR) | (state_q == FS_R);

  assign inst_o    = inst_q;
  assign valid_o   = valid_q;
  assign bus_err_o = bus_err_q;

  assign arid_o    = AR_ID;
  assign araddr_o  = araddr_q;
  assign arlen_o   = 8'd0;
  assign arsize_o  = AXI_SIZE_4B;
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign arprot_o  = 3'b000;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule : inst_uc_fetch

`default_nettype wire

// File: tb/tb_inst_uc_fetch.sv
// ============================================================================
// Module      : tb_inst_uc_fetch
// Description : Self-checking bench for inst_uc_fetch with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_uc_fetch;

  localparam int ID_W = 4;

  logic            clk;
  logic            rst_n;
  logic            req_i;
  logic [31:0]     addr_i;
  logic            flush_i;
  logic            stall_o;
  logic [31:0]     inst_o;
  logic            valid_o;
  logic            bus_err_o;
  logic [ID_W-1:0] arid_o;
  logic [31:0]     araddr_o;
  logic [7:0]      arlen_o;
  logic [2:0]      arsize_o;
  logic [1:0]      arburst_o;
  logic [1:0]      arlock_o;
  logic [3:0]      arcache_o;
  logic [2:0]      arprot_o;
  logic            arvalid_o;
  logic            arready_i;
  logic [ID_W-1:0] rid_i;
  logic [31:0]     rdata_i;
  logic [1:0]      rresp_i;
  logic            rlast_i;
  logic            rvalid_i;
  logic            rready_o;

  int vectors = 0;
  int fails   = 0;

  // Expected {bus_err, inst} for each non-killed fetch
  logic [32:0] sb_q[$];

  inst_uc_fetch #(.ID_W(ID_W), .AR_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .addr_i(addr_i), .flush_i(flush_i),
    .stall_o(stall_o), .inst_o(inst_o), .valid_o(valid_o), .bus_err_o(bus_err_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arlock_o(arlock_o), .arcache_o(arcache_o),
    .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid_o pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      logic [32:0] exp;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", {31'd0, valid_o}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_inst", inst_o, exp[31:0]);
        chk("sb_bus_err", {31'd0, bus_err_o}, {31'd0, exp[32]});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_i = 1'b0; addr_i = 32'h0; flush_i = 1'b0;
    arready_i = 1'b0; rid_i = '0; rdata_i = 32'h0; rresp_i = 2'b00;
    rlast_i = 1'b0; rvalid_i = 1'b0;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_araddr", araddr_o, 32'h0);
    chk("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    chk("rst_rready", {31'd0, rready_o}, 32'd0);
    chk("rst_stall_noreq", {31'd0, stall_o}, 32'd0);
    req_i = 1'b1; #1;
    chk("rst_stall_req", {31'd0, stall_o}, 32'd1);
    req_i = 1'b0;
    rst_n = 1'b1;
    step();

    // ---------------- basic fetch ----------------
    req_i = 1'b1; addr_i = 32'hbfc00000; #1;
    chk("basic_c0_stall", {31'd0, stall_o}, 32'd1);
    step();
    req_i = 1'b0; addr_i = 32'h0; arready_i = 1'b1;
    chk("basic_c1_arvalid", {31'd0, arvalid_o}, 32'd1);
    chk("basic_c1_araddr", araddr_o, 32'hbfc00000);
    chk("basic_c1_arlen", {24'd0, arlen_o}, 32'd0);
    chk("basic_c1_arsize", {29'd0, arsize_o}, 32'd2);
    chk("basic_c1_arburst", {30'd0, arburst_o}, 32'd1);
    chk("basic_c1_arid", {28'd0, arid_o}, 32'd0);
    chk("basic_c1_stall", {31'd0, stall_o}, 32'd1);
    step();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'h3c1abfc0; rresp_i = 2'b00;
    sb_q.push_back({1'b0, 32'h3c1abfc0});
    chk("basic_c2_rready", {31'd0, rready_o}, 32'd1);
    chk("basic_c2_arvalid", {31'd0, arvalid_o}, 32'd0);
    chk("basic_c2_stall", {31'd0, stall_o}, 32'd1);
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    chk("basic_c3_valid", {31'd0, valid_o}, 32'd1);
    chk("basic_c3_inst", inst_o, 32'h3c1abfc0);
    chk("basic_c3_stall", {31'd0, stall_o}, 32'd0);
    chk("basic_c3_rready", {31'd0, rready_o}, 32'd0);
    step();
    chk("basic_c4_valid", {31'd0, valid_o}, 32'd0);
    chk("basic_c4_inst_hold", inst_o, 32'h3c1abfc0);

    // ---------------- flush in R ----------------
    req_i = 1'b1; addr_i = 32'h00001000;
    step();
    req_i = 1'b0; arready_i = 1'b1;
    step();
    arready_i = 1'b0; flush_i = 1'b1;
    chk("flushr_rready", {31'd0, rready_o}, 32'd1);
    step();
    flush_i = 1'b0;
    chk("flushr_wait_stall", {31'd0, stall_o}, 32'd1);
    rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'hdeadbeef;
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    chk("flushr_valid", {31'd0, valid_o}, 32'd0);
    chk("flushr_inst_kept", inst_o, 32'h3c1abfc0);
    chk("flushr_stall", {31'd0, stall_o}, 32'd0);
    chk("flushr_rready", {31'd0, rready_o}, 32'd0);
    chk("flushr_arvalid", {31'd0, arvalid_o}, 32'd0);
    step();
    chk("flushr_valid_later", {31'd0, valid_o}, 32'd0);

    // ---------------- back-pressure ----------------
    req_i = 1'b1; addr_i = 32'h80001000;
    step();
    req_i = 1'b0; addr_i = 32'hffffffff;
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid_held", {31'd0, arvalid_o}, 32'd1);
      chk("bp_araddr_held", araddr_o, 32'h80001000);
      chk("bp_stall", {31'd0, stall_o}, 32'd1);
      step();
    end
    arready_i = 1'b1;
    chk("bp_arvalid_at_ready", {31'd0, arvalid_o}, 32'd1);
    step();                                   // arready + 1
    arready_i = 1'b0;
    chk("bp_r_rready", {31'd0, rready_o}, 32'd1);
    step();                                   // arready + 2
    rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'h00000000;
    sb_q.push_back({1'b0, 32'h00000000});
    chk("bp_no_valid_yet", {31'd0, valid_o}, 32'd0);
    step();                                   // arready + 3
    rvalid_i = 1'b0; rlast_i = 1'b0;
    chk("bp_valid", {31'd0, valid_o}, 32'd1);
    chk("bp_inst", inst_o, 32'h00000000);
    step();

    // ---------------- flush with request in IDLE ----------------
    req_i = 1'b1; flush_i = 1'b1; addr_i = 32'h00005000; #1;
    chk("flreq_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("flreq_arvalid", {31'd0, arvalid_o}, 32'd0);
    chk("flreq_stall2", {31'd0, stall_o}, 32'd0);
    req_i = 1'b0; flush_i = 1'b0;
    step();
    chk("flreq_arvalid2", {31'd0, arvalid_o}, 32'd0);

    // ---------------- error response ----------------
    req_i = 1'b1; addr_i = 32'h00002000;
    step();
    req_i = 1'b0; arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'h12345678; rresp_i = 2'b10;
    sb_q.push_back({1'b1, 32'h12345678});
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
    chk("err_valid", {31'd0, valid_o}, 32'd1);
    chk("err_bus_err", {31'd0, bus_err_o}, 32'd1);
    step();
    chk("err_bus_err_pulse", {31'd0, bus_err_o}, 32'd0);

    // ---------------- reset mid-operation ----------------
    req_i = 1'b1; addr_i = 32'h00003000;
    step();
    req_i = 1'b0;
    chk("rstmid_arvalid_before", {31'd0, arvalid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_arvalid_async", {31'd0, arvalid_o}, 32'd0);
    chk("rstmid_araddr", araddr_o, 32'h0);
    chk("rstmid_inst", inst_o, 32'h0);
    chk("rstmid_stall", {31'd0, stall_o}, 32'd0);
    chk("rstmid_rready", {31'd0, rready_o}, 32'd0);
    step();
    rst_n = 1'b1;
    req_i = 1'b1; addr_i = 32'h00004000;
    step();
    req_i = 1'b0; arready_i = 1'b1;
    chk("rstmid_new_arvalid", {31'd0, arvalid_o}, 32'd1);
    chk("rstmid_new_araddr", araddr_o, 32'h00004000);
    step();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'hcafef00d;
    sb_q.push_back({1'b0, 32'hcafef00d});
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    chk("rstmid_new_valid", {31'd0, valid_o}, 32'd1);
    step(); step();

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_inst_uc_fetch

`default_nettype wire
